// File: rtl/dac_stream_bridge.sv
// Elastic AXI-Stream output stage for 256-bit DAC words with priming, underrun fill and overrun drop.
// Build option DAC_STREAM_HOLD_LAST_EN: underrun repeats the last sent word instead of zero.
module dac_stream_bridge #(
  parameter int DEPTH_LOG2      = 3,
  parameter int ENABLE_REG_ADDR = 0,
  parameter int THRESH_REG_ADDR = 0,
  parameter int CLEAR_REG_ADDR  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  gpio_in,
  input  logic [255:0] din,
  input  logic         din_valid,
  output logic [255:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [15:0]  underrun_cnt,
  output logic [15:0]  overrun_cnt,
  output logic         streaming
);

  localparam int DATA_W = 256;
  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int PW     = DEPTH_LOG2;
  localparam int CW     = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  function automatic logic [CW-1:0] clamp_thresh(input logic [7:0] t);
    if (t == 8'd0)              return CW'(1);
    else if (t > 8'(DEPTH))     return CW'(DEPTH);
    else                        return CW'(t);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Config bus: act on the rising edge of the write strobe
  logic        w_clk_p0;
  logic        gpio_wr, clr;
  logic        enable_q;
  logic [7:0]  thresh_q;

  assign gpio_wr = gpio_in[24] & ~w_clk_p0;
  assign clr     = gpio_wr && (gpio_in[15:0] == 16'(CLEAR_REG_ADDR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_clk_p0 <= 1'b0;
      enable_q <= 1'b0;
      thresh_q <= 8'd1;
    end else begin
      w_clk_p0 <= gpio_in[24];
      if (gpio_wr && (gpio_in[15:0] == 16'(ENABLE_REG_ADDR))) enable_q <= gpio_in[16];
      if (gpio_wr && (gpio_in[15:0] == 16'(THRESH_REG_ADDR))) thresh_q <= gpio_in[23:16];
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              full, empty;
  state_t            state_q, state_d;
  logic              flush, rd_en, wr_en, underrun_ev, overrun_ev;
  logic [DATA_W-1:0] tdata_p1;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    state_d     = state_q;
    flush       = 1'b0;
    rd_en       = 1'b0;
    underrun_ev = 1'b0;
    case (state_q)
      IDLE: begin
        flush = 1'b1;
        if (enable_q) state_d = PRIME;
      end
      PRIME: begin
        // Preload the output register on entry so the first beat is real data
        if (count_q >= clamp_thresh(thresh_q)) begin
          state_d = STREAM;
          rd_en   = 1'b1;
        end
      end
      STREAM: begin
        if (m_axis_tready) begin
          if (!empty) rd_en = 1'b1;
          else        underrun_ev = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable_q) begin
      state_d = IDLE;
      flush   = 1'b1;
    end
  end

  // A read in the same cycle frees a slot, so a write at full is still accepted
  assign wr_en      = din_valid && !flush && (!full || rd_en);
  assign overrun_ev = din_valid && !flush && full && !rd_en;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      underrun_cnt <= 16'd0;
      overrun_cnt  <= 16'd0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(wr_en) - CW'(rd_en);
      end
      if (clr) begin
        underrun_cnt <= 16'd0;
        overrun_cnt  <= 16'd0;
      end else begin
        if (underrun_ev) underrun_cnt <= sat_inc(underrun_cnt);
        if (overrun_ev)  overrun_cnt  <= sat_inc(overrun_cnt);
      end
    end
  end

  // Output register stage: only reloaded when the current beat is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tdata_p1 <= '0;
    end else if (flush) begin
      tdata_p1 <= '0;
    end else if (rd_en) begin
      tdata_p1 <= mem[rd_ptr_q];
    end else if (underrun_ev) begin
`ifdef DAC_STREAM_HOLD_LAST_EN
      tdata_p1 <= tdata_p1;
`else
      tdata_p1 <= '0;
`endif
    end
  end

  assign streaming     = (state_q == STREAM);
  assign m_axis_tvalid = streaming;
  assign m_axis_tdata  = tdata_p1;

endmodule

// File: tb/tb_dac_stream_bridge.sv
// Directed bench for dac_stream_bridge: priming, back-pressure, overrun, underrun,
// disable/flush, counter clear, saturation and asynchronous reset.
module tb_dac_stream_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  gpio_in;
  logic [255:0] din;
  logic         din_valid;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [15:0]  underrun_cnt;
  logic [15:0]  overrun_cnt;
  logic         streaming;

  int n_cmp = 0;
  int n_bad = 0;

  dac_stream_bridge #(
    .DEPTH_LOG2(3), .ENABLE_REG_ADDR(1), .THRESH_REG_ADDR(2), .CLEAR_REG_ADDR(3)
  ) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .din(din), .din_valid(din_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt), .streaming(streaming)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gpio_write(input logic [15:0] addr, input logic [7:0] data);
    gpio_in = {7'd0, 1'b1, data, addr};
    tick();
    gpio_in = {7'd0, 1'b0, data, addr};
    tick();
  endtask

  function automatic logic [255:0] word(input logic [15:0] tag);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[i*16 +: 16] = tag + 16'(i);
    return w;
  endfunction

  function automatic logic [255:0] idle_word(input logic [255:0] last);
`ifdef DAC_STREAM_HOLD_LAST_EN
    return last;
`else
    return 256'h0 & last;
`endif
  endfunction

  task automatic push(input logic [255:0] w);
    din = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  initial begin
    logic [255:0] wa, wb, wc, wd, we, wf;
    logic [255:0] w [11];
    rst = 1'b0;
    gpio_in = '0;
    din = '0;
    din_valid = 1'b0;
    m_axis_tready = 1'b0;
    wa = word(16'h1000); wb = word(16'h2000); wc = word(16'h3000); wd = word(16'h4000);
    we = word(16'h5000); wf = word(16'h6000);
    for (int i = 0; i < 11; i++) w[i] = word(16'h8000 + 16'(i * 16'h100));

    // Reset state
    #3;
    check("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
    check("rst_stream", 256'(streaming), 256'd0);
    check("rst_tdata", m_axis_tdata, 256'd0);
    check("rst_ucnt", 256'(underrun_cnt), 256'd0);
    check("rst_ocnt", 256'(overrun_cnt), 256'd0);
    tick();
    rst = 1'b1;
    tick();

    // Prime with threshold 4
    gpio_write(16'd2, 8'd4);
    gpio_write(16'd1, 8'd1);
    check("prime_idle_tvalid", 256'(m_axis_tvalid), 256'd0);
    push(wa); push(wb); push(wc); push(wd);
    check("prime_after_d_tvalid", 256'(m_axis_tvalid), 256'd0);
    tick();
    check("prime_tvalid", 256'(m_axis_tvalid), 256'd1);
    check("prime_stream", 256'(streaming), 256'd1);
    check("prime_a", m_axis_tdata, wa);
    tick();
    check("prime_a_held", m_axis_tdata, wa);
    m_axis_tready = 1'b1;
    tick(); check("prime_b", m_axis_tdata, wb);
    tick(); check("prime_c", m_axis_tdata, wc);
    tick(); check("prime_d", m_axis_tdata, wd);
    m_axis_tready = 1'b0;
    check("prime_no_underrun", 256'(underrun_cnt), 256'd0);

    // Back-pressure: fill to full, two words dropped
    for (int i = 0; i < 10; i++) push(w[i]);
    check("bp_tdata_held", m_axis_tdata, wd);
    check("bp_overrun", 256'(overrun_cnt), 256'd2);
    // Read and write together at full: write accepted
    m_axis_tready = 1'b1;
    push(w[10]);
    check("bp_full_rw_w0", m_axis_tdata, w[0]);
    check("bp_full_rw_ocnt", 256'(overrun_cnt), 256'd2);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("bp_drain_%0d", i), m_axis_tdata, w[i]);
    end
    tick();
    check("bp_drain_w10", m_axis_tdata, w[10]);
    check("bp_drain_ucnt", 256'(underrun_cnt), 256'd0);

    // Underrun: three accepted beats with empty FIFO
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("ur_cnt_%0d", i), 256'(underrun_cnt), 256'(i));
      check($sformatf("ur_tdata_%0d", i), m_axis_tdata, idle_word(w[10]));
      check($sformatf("ur_tvalid_%0d", i), 256'(m_axis_tvalid), 256'd1);
    end
    m_axis_tready = 1'b0;
    push(we);
    m_axis_tready = 1'b1;
    tick();
    check("ur_recover_e", m_axis_tdata, we);
    check("ur_recover_cnt", 256'(underrun_cnt), 256'd3);
    m_axis_tready = 1'b0;

    // Disable flushes leftovers; counters survive
    push(wa); push(wb);
    gpio_write(16'd1, 8'd0);
    check("dis_tvalid", 256'(m_axis_tvalid), 256'd0);
    check("dis_stream", 256'(streaming), 256'd0);
    check("dis_ucnt_kept", 256'(underrun_cnt), 256'd3);
    check("dis_ocnt_kept", 256'(overrun_cnt), 256'd2);
    gpio_write(16'd2, 8'd1);
    gpio_write(16'd1, 8'd1);
    push(wf);
    check("lat_1cyc_tvalid", 256'(m_axis_tvalid), 256'd0);
    tick();
    check("lat_2cyc_tvalid", 256'(m_axis_tvalid), 256'd1);
    check("lat_2cyc_f_flushed", m_axis_tdata, wf);
    gpio_write(16'd3, 8'd0);
    check("clr_ucnt", 256'(underrun_cnt), 256'd0);
    check("clr_ocnt", 256'(overrun_cnt), 256'd0);

    // Saturation
    m_axis_tready = 1'b1;
    repeat (65540) tick();
    check("sat_ucnt", 256'(underrun_cnt), 256'hFFFF);
    check("sat_ocnt", 256'(overrun_cnt), 256'd0);
    check("sat_tdata", m_axis_tdata, idle_word(wf));

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b0;
    #1;
    check("arst_tvalid", 256'(m_axis_tvalid), 256'd0);
    check("arst_stream", 256'(streaming), 256'd0);
    check("arst_ucnt", 256'(underrun_cnt), 256'd0);
    check("arst_tdata", m_axis_tdata, 256'd0);
    tick();
    rst = 1'b1;
    push(wa);
    tick(); tick();
    check("arst_idle_stream", 256'(streaming), 256'd0);
    check("arst_idle_tvalid", 256'(m_axis_tvalid), 256'd0);
    check("arst_idle_ocnt", 256'(overrun_cnt), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
